// File: rtl/ad_line_fifo.sv
// Line recovery + FWFT pixel FIFO: tags SOF/EOL from idle gaps, drops to next frame on overflow.
// Latency: >=2 clocks inde->out_valid; backpressure via out_ready, upstream overflow is sticky.
// Optional AD_LINE_STATS_EN adds line_width/frame_height statistics.
module ad_line_fifo #(
    parameter int DEPTH = 16,
    parameter int GAP   = 16,
    parameter int XW    = 11,
    parameter int YW    = 11
) (
    input  logic          adclk,
    input  logic          adrstn,
    input  logic          inde,
    input  logic [24:0]   indat,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [23:0]   out_dat,
    output logic          out_sof,
    output logic          out_eol,
    output logic          overflow,
    input  logic          clr_ovf
`ifdef AD_LINE_STATS_EN
    ,
    output logic [XW-1:0] line_width,
    output logic [YW-1:0] frame_height
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] GAP_C = 8'(GAP);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DROP} state_t;

    state_t        state_q, state_d;
    logic          stg_vld_q, stg_vld_d;
    logic [24:0]   stg_q, stg_d;
    logic [7:0]    gap_q, gap_d;
    logic [25:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          ovf_q;
    logic          take, push, push_ok, pop, ovf_set;
    logic [25:0]   push_dat, head;

    assign head      = mem_q[rd_q];
    assign out_valid = (cnt_q != '0);
    assign out_dat   = out_valid ? head[23:0] : 24'd0;
    assign out_sof   = out_valid & head[25];
    assign out_eol   = out_valid & head[24];
    assign overflow  = ovf_q;
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && !ovf_set;

    always_comb begin
        state_d   = state_q;
        stg_vld_d = stg_vld_q;
        stg_d     = stg_q;
        push      = 1'b0;
        push_dat  = '0;
        ovf_set   = 1'b0;
        take      = inde && (state_q == S_RUN || indat[24]);
        if (inde)
            gap_d = 8'd0;
        else if (gap_q != GAP_C)
            gap_d = gap_q + 8'd1;
        else
            gap_d = gap_q;

        if (take) begin
            // A new SOF closes the previous line even without an idle gap.
            push      = stg_vld_q;
            push_dat  = {stg_q[24], indat[24], stg_q[23:0]};
            stg_vld_d = 1'b1;
            stg_d     = indat;
            state_d   = S_RUN;
        end else if (!inde && stg_vld_q && gap_q == GAP_C - 8'd1) begin
            push      = 1'b1;
            push_dat  = {stg_q[24], 1'b1, stg_q[23:0]};
            stg_vld_d = 1'b0;
        end

        if (push && cnt_q == FULL_C && !pop) begin
            ovf_set   = 1'b1;
            stg_vld_d = 1'b0;
            state_d   = S_DROP;
        end
    end

    always_ff @(posedge adclk or negedge adrstn) begin
        if (!adrstn) begin
            state_q   <= S_IDLE;
            stg_vld_q <= 1'b0;
            stg_q     <= '0;
            gap_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            stg_vld_q <= stg_vld_d;
            stg_q     <= stg_d;
            gap_q     <= gap_d;
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            cnt_q     <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge adclk) begin
        if (push_ok) mem_q[wr_q] <= push_dat;
    end

`ifdef AD_LINE_STATS_EN
    logic [XW-1:0] x_q, lw_q;
    logic [YW-1:0] y_q, fh_q;

    assign line_width   = lw_q;
    assign frame_height = fh_q;

    always_ff @(posedge adclk or negedge adrstn) begin
        if (!adrstn) begin
            x_q  <= '0;
            y_q  <= '0;
            lw_q <= '0;
            fh_q <= '0;
        end else if (push_ok) begin
            if (push_dat[24]) begin
                x_q  <= '0;
                lw_q <= x_q + 1'b1;
            end else if (x_q != '1) begin
                x_q <= x_q + 1'b1;
            end
            if (push_dat[25]) begin
                fh_q <= y_q;
                y_q  <= push_dat[24] ? YW'(1) : '0;
            end else if (push_dat[24] && y_q != '1) begin
                y_q <= y_q + 1'b1;
            end
        end
    end
`endif

endmodule
